// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_access.sv
// Pipeline stage 4 memory access: issues one registered data-memory request per
// aligned load/store, stalls earlier stages until the ack, then presents writeback.
module mem_access (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         valid_in,
    input  logic         mem_r_in,
    input  logic         mem_w_in,
    input  logic [1:0]   mem_size_in,
    input  logic         mem_sext_in,
    input  logic [31:0]  addr_in,
    input  logic [31:0]  wdata_in,
    input  logic         regfile_w_en_in,
    input  logic [4:0]   regfile_req_w_in,
    mem_access_if.master dm,
    output logic         stall,
    output logic         valid_out,
    output logic         regfile_w_en,
    output logic [4:0]   regfile_req_w,
    output logic         r_datamem,
    output logic [31:0]  load_data,
    output logic         misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic        kill_reg, kill_next;
    logic        post_rst_reg;

    logic [1:0]  size_reg;
    logic        sext_reg;
    logic [1:0]  off_reg;
    logic        load_reg;
    logic        rf_w_en_reg;
    logic [4:0]  rf_req_w_reg;
    logic [31:0] load_data_reg;

    logic        dm_req_reg;
    logic        dm_we_reg;
    logic [31:0] dm_addr_reg;
    logic [3:0]  dm_be_reg;
    logic [31:0] dm_wdata_reg;

    logic        accept;
    logic        ack_take;
    logic        mem_op;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  rd_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    assign dm.dm_req   = dm_req_reg;
    assign dm.dm_we    = dm_we_reg;
    assign dm.dm_addr  = dm_addr_reg;
    assign dm.dm_be    = dm_be_reg;
    assign dm.dm_wdata = dm_wdata_reg;

    assign mem_op     = mem_r_in | mem_w_in;
    // Size 11 decodes as word, so only bit 1 is needed to recognise a word access.
    assign misaligned = ((mem_size_in == 2'b01) && addr_in[0]) ||
                        (mem_size_in[1] && (addr_in[1:0] != 2'b00));
    assign ack_take   = (state_reg == S_REQ) && dm.dm_ack;

    // Per-lane byte enables, store-data replication and read-lane split.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign be_next[gi] = mem_size_in[1] ? 1'b1 :
                                 mem_size_in[0] ? (addr_in[1] == LANE[1]) :
                                                  (addr_in[1:0] == LANE);

            assign wdata_next[8*gi +: 8] = mem_size_in[1] ? wdata_in[8*gi +: 8] :
                                           mem_size_in[0] ? wdata_in[8*(gi%2) +: 8] :
                                                            wdata_in[7:0];

            assign rd_lane[gi] = dm.dm_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte = rd_lane[off_reg];
        sel_half = off_reg[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        if (size_reg[1]) begin
            load_ext = dm.dm_rdata;
        end else if (size_reg[0]) begin
            load_ext = {{16{sext_reg & sel_half[15]}}, sel_half};
        end else begin
            load_ext = {{24{sext_reg & sel_byte[7]}}, sel_byte};
        end
    end

    always_comb begin
        state_next    = state_reg;
        kill_next     = kill_reg;
        accept        = 1'b0;
        stall         = 1'b0;
        valid_out     = 1'b0;
        regfile_w_en  = 1'b0;
        regfile_req_w = 5'd0;
        r_datamem     = 1'b0;
        load_data     = 32'd0;
        misalign      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // The first cycle after reset is treated as a bubble.
                if (valid_in && !clear && !post_rst_reg) begin
                    if (!mem_op) begin
                        valid_out     = 1'b1;
                        regfile_w_en  = regfile_w_en_in;
                        regfile_req_w = regfile_req_w_in;
                    end else if (misaligned) begin
                        misalign      = 1'b1;
                        valid_out     = 1'b1;
                        regfile_req_w = regfile_req_w_in;
                    end else begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        kill_next  = 1'b0;
                        state_next = S_REQ;
                    end
                end
            end

            S_REQ: begin
                stall = 1'b1;
                if (clear) begin
                    kill_next = 1'b1;
                end
                // A flushed access still completes its handshake, then skips RESP.
                if (dm.dm_ack) begin
                    kill_next  = 1'b0;
                    state_next = (kill_reg || clear) ? S_IDLE : S_RESP;
                end
            end

            S_RESP: begin
                state_next = S_IDLE;
                if (!clear) begin
                    valid_out     = 1'b1;
                    regfile_w_en  = rf_w_en_reg;
                    regfile_req_w = rf_req_w_reg;
                    r_datamem     = load_reg;
                    load_data     = load_data_reg;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (rst) begin
            accept        = 1'b0;
            stall         = 1'b0;
            valid_out     = 1'b0;
            regfile_w_en  = 1'b0;
            regfile_req_w = 5'd0;
            r_datamem     = 1'b0;
            load_data     = 32'd0;
            misalign      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            kill_reg      <= 1'b0;
            post_rst_reg  <= 1'b1;
            size_reg      <= 2'd0;
            sext_reg      <= 1'b0;
            off_reg       <= 2'd0;
            load_reg      <= 1'b0;
            rf_w_en_reg   <= 1'b0;
            rf_req_w_reg  <= 5'd0;
            load_data_reg <= 32'd0;
            dm_req_reg    <= 1'b0;
            dm_we_reg     <= 1'b0;
            dm_addr_reg   <= 32'd0;
            dm_be_reg     <= 4'd0;
            dm_wdata_reg  <= 32'd0;
        end else begin
            state_reg    <= state_next;
            kill_reg     <= kill_next;
            post_rst_reg <= 1'b0;
            if (accept) begin
                dm_req_reg   <= 1'b1;
                dm_we_reg    <= mem_w_in;
                dm_addr_reg  <= {addr_in[31:2], 2'b00};
                dm_be_reg    <= be_next;
                dm_wdata_reg <= wdata_next;
                size_reg     <= mem_size_in;
                sext_reg     <= mem_sext_in;
                off_reg      <= addr_in[1:0];
                load_reg     <= mem_r_in;
                rf_w_en_reg  <= regfile_w_en_in;
                rf_req_w_reg <= regfile_req_w_in;
            end else if (ack_take) begin
                dm_req_reg    <= 1'b0;
                dm_we_reg     <= 1'b0;
                load_data_reg <= load_reg ? load_ext : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads/stores of each size, misalignment,
// flushes in every state and reset during an outstanding request.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        valid_in;
    logic        mem_r_in;
    logic        mem_w_in;
    logic [1:0]  mem_size_in;
    logic        mem_sext_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        regfile_w_en_in;
    logic [4:0]  regfile_req_w_in;
    logic        stall;
    logic        valid_out;
    logic        regfile_w_en;
    logic [4:0]  regfile_req_w;
    logic        r_datamem;
    logic [31:0] load_data;
    logic        misalign;

    int n_total;
    int n_bad;
    int stall_cnt;

    mem_access_if dm_bus ();

    mem_access dut (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear),
        .valid_in         (valid_in),
        .mem_r_in         (mem_r_in),
        .mem_w_in         (mem_w_in),
        .mem_size_in      (mem_size_in),
        .mem_sext_in      (mem_sext_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .regfile_w_en_in  (regfile_w_en_in),
        .regfile_req_w_in (regfile_req_w_in),
        .dm               (dm_bus),
        .stall            (stall),
        .valid_out        (valid_out),
        .regfile_w_en     (regfile_w_en),
        .regfile_req_w    (regfile_req_w),
        .r_datamem        (r_datamem),
        .load_data        (load_data),
        .misalign         (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        if (stall) stall_cnt++;
    endtask

    task automatic idle_inputs();
        clear            = 1'b0;
        valid_in         = 1'b0;
        mem_r_in         = 1'b0;
        mem_w_in         = 1'b0;
        mem_size_in      = 2'b00;
        mem_sext_in      = 1'b0;
        addr_in          = 32'd0;
        wdata_in         = 32'd0;
        regfile_w_en_in  = 1'b0;
        regfile_req_w_in = 5'd0;
        dm_bus.dm_ack    = 1'b0;
        dm_bus.dm_rdata  = 32'd0;
    endtask

    task automatic drive_op(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic wen, input logic [4:0] rd_idx);
        valid_in         = 1'b1;
        mem_r_in         = r;
        mem_w_in         = w;
        mem_size_in      = sz;
        mem_sext_in      = sx;
        addr_in          = addr;
        wdata_in         = wd;
        regfile_w_en_in  = wen;
        regfile_req_w_in = rd_idx;
    endtask

    // Full accepted access: ack on the n_wait-th request cycle, then check RESP.
    task automatic run_access(input string tag, input logic r, input logic w,
                              input logic [1:0] sz, input logic sx,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int n_wait,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_ld);
        stall_cnt = 0;
        next_cycle();
        drive_op(r, w, sz, sx, addr, wd, 1'b1, 5'd11);
        sample();
        chk_eq({tag, ".acc_stall"}, stall, 1);
        chk_eq({tag, ".acc_valid"}, valid_out, 0);
        for (int i = 1; i <= n_wait; i++) begin
            next_cycle();
            dm_bus.dm_ack   = (i == n_wait);
            dm_bus.dm_rdata = (i == n_wait) ? rd : 32'hDEAD_BEEF;
            sample();
            chk_eq({tag, ".req"}, dm_bus.dm_req, 1);
            if (i == 1) begin
                chk_eq({tag, ".addr"}, dm_bus.dm_addr, {addr[31:2], 2'b00});
                chk_eq({tag, ".be"}, dm_bus.dm_be, exp_be);
                chk_eq({tag, ".we"}, dm_bus.dm_we, w);
                if (w) chk_eq({tag, ".wdata"}, dm_bus.dm_wdata, exp_wd);
            end
        end
        next_cycle();
        idle_inputs();
        sample();
        chk_eq({tag, ".resp_valid"}, valid_out, 1);
        chk_eq({tag, ".resp_stall"}, stall, 0);
        chk_eq({tag, ".resp_rdm"}, r_datamem, r);
        chk_eq({tag, ".resp_ld"}, load_data, exp_ld);
        chk_eq({tag, ".resp_wen"}, regfile_w_en, 1);
        chk_eq({tag, ".resp_rd"}, regfile_req_w, 11);
        chk_eq({tag, ".resp_req"}, dm_bus.dm_req, 0);
        chk_eq({tag, ".stall_cycles"}, stall_cnt, n_wait + 1);
        $display("txn %s addr=%h load_data=%h stall_cycles=%0d", tag, addr, load_data, stall_cnt);
        next_cycle();
        sample();
        chk_eq({tag, ".after_valid"}, valid_out, 0);
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        stall_cnt = 0;
        idle_inputs();
        rst = 1'b1;

        // Reset with an ALU op presented: everything stays quiet.
        drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5);
        next_cycle();
        sample();
        chk_eq("rst.stall", stall, 0);
        chk_eq("rst.valid", valid_out, 0);
        chk_eq("rst.wen", regfile_w_en, 0);
        chk_eq("rst.rd", regfile_req_w, 0);
        chk_eq("rst.req", dm_bus.dm_req, 0);
        chk_eq("rst.addr", dm_bus.dm_addr, 0);
        chk_eq("rst.be", dm_bus.dm_be, 0);
        chk_eq("rst.wdata", dm_bus.dm_wdata, 0);
        next_cycle();
        rst = 1'b0;
        sample();
        chk_eq("post_rst.valid", valid_out, 0);
        chk_eq("post_rst.wen", regfile_w_en, 0);
        $display("txn reset valid_out=%0d stall=%0d", valid_out, stall);

        // ALU op passes straight through.
        next_cycle();
        drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 5'd7);
        sample();
        chk_eq("alu.valid", valid_out, 1);
        chk_eq("alu.wen", regfile_w_en, 1);
        chk_eq("alu.rd", regfile_req_w, 7);
        chk_eq("alu.stall", stall, 0);
        chk_eq("alu.rdm", r_datamem, 0);
        chk_eq("alu.ld", load_data, 0);
        $display("txn alu rd=%0d valid_out=%0d", regfile_req_w, valid_out);

        run_access("lb_sext",  1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,
                   32'h80FF_FFFF, 2, 4'b1000, 32'h0, 32'hFFFF_FF80);
        run_access("sh",       1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_ABCD,
                   32'h5555_5555, 1, 4'b1100, 32'hABCD_ABCD, 32'h0);
        run_access("sb",       1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0007, 32'h0000_00A5,
                   32'h0, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        run_access("sw",       1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0044, 32'h1122_3344,
                   32'h0, 3, 4'b1111, 32'h1122_3344, 32'h0);
        run_access("lhu_hi",   1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,
                   32'h8001_1234, 1, 4'b1100, 32'h0, 32'h0000_8001);
        run_access("lh_lo",    1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0,
                   32'h1234_8001, 2, 4'b0011, 32'h0, 32'hFFFF_8001);
        run_access("lbu_l1",   1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,
                   32'h0000_9900, 1, 4'b0010, 32'h0, 32'h0000_0099);
        run_access("lw_sz11",  1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0,
                   32'hCAFE_F00D, 1, 4'b1111, 32'h0, 32'hCAFE_F00D);

        // Misaligned word load: flagged, no request, no writeback.
        next_cycle();
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0041, 32'h0, 1'b1, 5'd4);
        sample();
        chk_eq("mis.flag", misalign, 1);
        chk_eq("mis.stall", stall, 0);
        chk_eq("mis.valid", valid_out, 1);
        chk_eq("mis.wen", regfile_w_en, 0);
        next_cycle();
        idle_inputs();
        sample();
        chk_eq("mis.req", dm_bus.dm_req, 0);
        chk_eq("mis.flag_drop", misalign, 0);
        $display("txn misalign addr=00000041 dm_req=%0d", dm_bus.dm_req);

        // Clear in IDLE on an aligned load, with a stray ack that must be ignored.
        next_cycle();
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 5'd2);
        clear         = 1'b1;
        dm_bus.dm_ack = 1'b1;
        sample();
        chk_eq("clr_idle.stall", stall, 0);
        chk_eq("clr_idle.valid", valid_out, 0);
        chk_eq("clr_idle.mis", misalign, 0);
        next_cycle();
        idle_inputs();
        sample();
        chk_eq("clr_idle.req", dm_bus.dm_req, 0);
        $display("txn clear_idle dm_req=%0d", dm_bus.dm_req);

        // Clear in the 2nd request cycle, ack three cycles later: no RESP.
        next_cycle();
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 1'b1, 5'd6);
        sample();
        chk_eq("clr_req.acc_stall", stall, 1);
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            clear         = (i == 2);
            dm_bus.dm_ack = (i == 5);
            dm_bus.dm_rdata = 32'h1357_9BDF;
            sample();
            chk_eq("clr_req.req", dm_bus.dm_req, 1);
            chk_eq("clr_req.stall", stall, 1);
            chk_eq("clr_req.valid", valid_out, 0);
        end
        next_cycle();
        idle_inputs();
        sample();
        chk_eq("clr_req.post_stall", stall, 0);
        chk_eq("clr_req.post_valid", valid_out, 0);
        chk_eq("clr_req.post_rdm", r_datamem, 0);
        chk_eq("clr_req.post_req", dm_bus.dm_req, 0);
        $display("txn clear_req valid_out=%0d stall=%0d", valid_out, stall);

        // Clear during RESP kills the writeback; next op proceeds from IDLE.
        next_cycle();
        drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 5'd8);
        sample();
        next_cycle();
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 32'h0000_0077;
        sample();
        next_cycle();
        idle_inputs();
        clear = 1'b1;
        sample();
        chk_eq("clr_resp.valid", valid_out, 0);
        chk_eq("clr_resp.wen", regfile_w_en, 0);
        chk_eq("clr_resp.rdm", r_datamem, 0);
        next_cycle();
        clear = 1'b0;
        drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 5'd9);
        sample();
        chk_eq("clr_resp.next_valid", valid_out, 1);
        chk_eq("clr_resp.next_rd", regfile_req_w, 9);
        $display("txn clear_resp next_rd=%0d", regfile_req_w);

        // Reset while a request is outstanding.
        next_cycle();
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 1'b1, 5'd3);
        sample();
        next_cycle();
        sample();
        chk_eq("rst_req.req_before", dm_bus.dm_req, 1);
        next_cycle();
        rst = 1'b1;
        sample();
        chk_eq("rst_req.stall", stall, 0);
        chk_eq("rst_req.valid", valid_out, 0);
        next_cycle();
        rst = 1'b0;
        drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 5'd12);
        sample();
        chk_eq("rst_req.req", dm_bus.dm_req, 0);
        chk_eq("rst_req.we", dm_bus.dm_we, 0);
        chk_eq("rst_req.addr", dm_bus.dm_addr, 0);
        chk_eq("rst_req.be", dm_bus.dm_be, 0);
        chk_eq("rst_req.post_stall", stall, 0);
        chk_eq("rst_req.post_valid", valid_out, 0);
        chk_eq("rst_req.post_ld", load_data, 0);
        next_cycle();
        sample();
        chk_eq("rst_req.alu_valid", valid_out, 1);
        chk_eq("rst_req.alu_stall", stall, 0);
        chk_eq("rst_req.alu_rd", regfile_req_w, 12);
        $display("txn reset_mid_req dm_req=%0d alu_valid=%0d", dm_bus.dm_req, valid_out);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
